// File: rtl/pc_flow_pkg.sv
// ----------------------------------------------------------------------------
// pc_flow_pkg
// Shared definitions for the program-counter / flow-control unit.
//   - FLOW opcode encodings driven by the control unit
//   - FSM state type for the RUN / HALT machine
// ----------------------------------------------------------------------------
package pc_flow_pkg;

    localparam int unsigned FLOW_WIDTH = 3;

    // FLOW encodings; 3'b110 and 3'b111 are unused and behave as NEXT.
    localparam logic [FLOW_WIDTH-1:0] FLOW_NEXT = 3'b000;
    localparam logic [FLOW_WIDTH-1:0] FLOW_JUMP = 3'b001;
    localparam logic [FLOW_WIDTH-1:0] FLOW_BEQ  = 3'b010;
    localparam logic [FLOW_WIDTH-1:0] FLOW_BNE  = 3'b011;
    localparam logic [FLOW_WIDTH-1:0] FLOW_CALL = 3'b100;
    localparam logic [FLOW_WIDTH-1:0] FLOW_RET  = 3'b101;

    // HALT is only left through reset.
    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } flow_state_e;

endpackage

// File: rtl/pc_flow_unit_ras_stack.sv
// ----------------------------------------------------------------------------
// ras_stack
// Return-address stack: DEPTH x WIDTH LIFO with registered occupancy count.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset (clears the count only)
//   i_push   write i_din on top (ignored when full)
//   i_pop    discard top entry (ignored when empty)
//   i_din    address to push
//   o_top    current top entry (undefined while empty)
//   o_empty  count == 0
//   o_full   count == DEPTH
// ----------------------------------------------------------------------------
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;

    logic             w_do_push;
    logic             w_do_pop;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CNT_W'(DEPTH));

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty & ~i_push;

    // While not full the low count bits address the next free slot.
    assign w_wr_idx  = r_cnt[IDX_W-1:0];
    assign w_rd_idx  = r_cnt[IDX_W-1:0] - IDX_W'(1);
    assign o_top     = r_mem[w_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Stack contents need no reset; only the count gives them meaning.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/pc_flow_unit.sv
// ----------------------------------------------------------------------------
// pc_flow_unit
// Program counter and flow control for the single-cycle CPU: PC increment,
// relative branch/jump target, CALL/RET via a return-address stack, data
// memory stall hold and a HALT fault state on stack over/underflow.
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_busywait     data memory stall; 1 holds all state
//   i_flow         flow opcode (see pc_flow_pkg)
//   i_zero         ALU zero flag for BEQ/BNE
//   i_offset       signed offset in instructions
//   o_pc           current instruction address (registered)
//   o_next_pc      address loaded at the next enabled edge
//   o_taken        non-sequential target selected
//   o_stack_empty  RAS holds no entries
//   o_stack_full   RAS holds RAS_DEPTH entries
//   o_fault        unit is in HALT
// ----------------------------------------------------------------------------
module pc_flow_unit
    import pc_flow_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          OFFSET_WIDTH = 8,
    parameter int unsigned          INSTR_SHIFT  = 2,
    parameter int unsigned          RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_busywait,
    input  logic [FLOW_WIDTH-1:0]   i_flow,
    input  logic                    i_zero,
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    output logic [PC_WIDTH-1:0]     o_pc,
    output logic [PC_WIDTH-1:0]     o_next_pc,
    output logic                    o_taken,
    output logic                    o_stack_empty,
    output logic                    o_stack_full,
    output logic                    o_fault
);

    localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(1) << INSTR_SHIFT;

    flow_state_e         r_state;
    flow_state_e         w_state_d;
    logic [PC_WIDTH-1:0] r_pc;

    logic [PC_WIDTH-1:0] w_pcplus;
    logic [PC_WIDTH-1:0] w_offset_ext;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic                w_taken;
    logic                w_push;
    logic                w_pop;
    logic                w_ras_empty;
    logic                w_ras_full;

    // Address arithmetic wraps modulo 2^PC_WIDTH by construction.
    assign w_pcplus     = r_pc + PC_INC;
    assign w_offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){i_offset[OFFSET_WIDTH-1]}}, i_offset};
    assign w_target     = w_pcplus + (w_offset_ext << INSTR_SHIFT);

    always_comb begin
        w_next_pc = w_pcplus;
        w_taken   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_state_d = r_state;

        if (r_state == StHalt) begin
            w_next_pc = r_pc;
        end else begin
            case (i_flow)
                FLOW_JUMP: begin
                    w_next_pc = w_target;
                    w_taken   = 1'b1;
                end
                FLOW_BEQ: begin
                    if (i_zero) begin
                        w_next_pc = w_target;
                        w_taken   = 1'b1;
                    end
                end
                FLOW_BNE: begin
                    if (!i_zero) begin
                        w_next_pc = w_target;
                        w_taken   = 1'b1;
                    end
                end
                FLOW_CALL: begin
                    if (w_ras_full) begin
                        // Overflow: freeze PC and trap.
                        w_next_pc = r_pc;
                        w_state_d = StHalt;
                    end else begin
                        w_next_pc = w_target;
                        w_taken   = 1'b1;
                        w_push    = 1'b1;
                    end
                end
                FLOW_RET: begin
                    if (w_ras_empty) begin
                        // Underflow: freeze PC and trap.
                        w_next_pc = r_pc;
                        w_state_d = StHalt;
                    end else begin
                        w_next_pc = w_ras_top;
                        w_taken   = 1'b1;
                        w_pop     = 1'b1;
                    end
                end
                default: begin
                    w_next_pc = w_pcplus;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= StRun;
        end else if (!i_busywait) begin
            r_pc    <= w_next_pc;
            r_state <= w_state_d;
        end
    end

    // Stack updates share the enabled edge with the PC.
    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push & ~i_busywait),
        .i_pop   (w_pop & ~i_busywait),
        .i_din   (w_pcplus),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    assign o_pc          = r_pc;
    assign o_next_pc     = w_next_pc;
    assign o_taken       = w_taken;
    assign o_stack_empty = w_ras_empty;
    assign o_stack_full  = w_ras_full;
    assign o_fault       = (r_state == StHalt);

endmodule
